// File: rtl/tx_frame_ctrl.sv
// Transmit sequencer: buffers DATA-register words in a small FIFO and serialises
// each one as start / LSB-first data / optional even parity / stop at a programmable bit rate.
module tx_frame_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          cfg_enable,
  input  logic                          cfg_parity_en,
  input  logic [DIV_W-1:0]              cfg_baud_div,
  input  logic                          ovf_clr,
  input  logic                          wr_valid,
  input  logic [31:0]                   wr_data,
  output logic                          tx_out,
  output logic                          busy,
  output logic                          fifo_empty,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam int BCNT_W = $clog2(DATA_BITS + 1);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wptr;
  logic [PTR_W-1:0]       r_rptr;
  logic [LVL_W-1:0]       r_level;
  logic [LVL_W-1:0]       w_level_nxt;
  logic                   r_empty;
  logic                   r_full;
  logic                   r_ovf;

  logic [DIV_W-1:0]       r_cnt;
  logic [DIV_W-1:0]       r_div;
  logic [BCNT_W-1:0]      r_bitcnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_par_en;

  logic [DIV_W-1:0]       w_cnt_nxt;
  logic [DIV_W-1:0]       w_div_nxt;
  logic [BCNT_W-1:0]      w_bitcnt_nxt;
  logic [DATA_BITS-1:0]   w_shift_nxt;
  logic                   w_par_nxt;
  logic                   w_par_en_nxt;

  logic                   r_tx;
  logic                   r_busy;
  logic                   r_done;
  logic                   w_tx_nxt;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;

  logic                   w_tick;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [DATA_BITS-1:0]   w_head;
  logic                   w_unused;

  assign w_unused = ^wr_data[31:DATA_BITS];

  assign w_tick = (r_cnt == '0);
  assign w_head = r_mem[r_rptr];
  assign w_pop  = (r_state == S_IDLE) && (w_state_nxt == S_START);
  // A full FIFO still accepts a write when the same edge pops the head entry.
  assign w_push = wr_valid && (!r_full || w_pop);
  assign w_drop = wr_valid && r_full && !w_pop;
  assign w_level_nxt = r_level + LVL_W'(w_push) - LVL_W'(w_pop);

  // FIFO storage: data only, never reset
  always_ff @(posedge ACLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= wr_data[DATA_BITS-1:0];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LVL_W'(FIFO_DEPTH));
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // FSM state register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (cfg_enable && !r_empty) w_state_nxt = S_START;
      S_START:  if (w_tick) w_state_nxt = S_DATA;
      S_DATA:   if (w_tick && (r_bitcnt == LAST_BIT))
                  w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP:   if (w_tick) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Bit timing and shift datapath; frame settings are frozen at the pop
  always_comb begin
    w_cnt_nxt    = r_cnt;
    w_div_nxt    = r_div;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_par_nxt    = r_par;
    w_par_en_nxt = r_par_en;
    if (w_pop) begin
      w_cnt_nxt    = cfg_baud_div;
      w_div_nxt    = cfg_baud_div;
      w_par_en_nxt = cfg_parity_en;
      w_shift_nxt  = w_head;
      w_par_nxt    = ^w_head;
      w_bitcnt_nxt = '0;
    end else if (r_state != S_IDLE) begin
      if (w_tick) begin
        w_cnt_nxt = r_div;
        if (r_state == S_DATA) begin
          w_shift_nxt  = r_shift >> 1;
          w_bitcnt_nxt = r_bitcnt + BCNT_W'(1);
        end
      end else begin
        w_cnt_nxt = r_cnt - DIV_W'(1);
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_cnt    <= '0;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_par_en <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_div    <= w_div_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_par    <= w_par_nxt;
      r_par_en <= w_par_en_nxt;
    end
  end

  // Outputs decoded from next state so the registered line matches the state it enters
  always_comb begin
    w_tx_nxt   = 1'b1;
    w_busy_nxt = 1'b1;
    case (w_state_nxt)
      S_IDLE:   w_busy_nxt = 1'b0;
      S_START:  w_tx_nxt   = 1'b0;
      S_DATA:   w_tx_nxt   = w_shift_nxt[0];
      S_PARITY: w_tx_nxt   = w_par_nxt;
      S_STOP:   w_tx_nxt   = 1'b1;
      default:  w_busy_nxt = 1'b0;
    endcase
    w_done_nxt = (w_state_nxt == S_STOP) && (w_cnt_nxt == '0);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_tx   <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_tx_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  assign tx_out     = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign fifo_empty = r_empty;
  assign fifo_full  = r_full;
  assign fifo_level = r_level;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Bench for tx_frame_ctrl: directed and random writes compared every cycle against
// a queue-based model that expands each frame into its expected per-cycle line waveform.
module tb_tx_frame_ctrl;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic              ACLK = 1'b0;
  logic              ARESETN = 1'b0;
  logic              cfg_enable = 1'b0;
  logic              cfg_parity_en = 1'b0;
  logic [DIV_W-1:0]  cfg_baud_div = '0;
  logic              ovf_clr = 1'b0;
  logic              wr_valid = 1'b0;
  logic [31:0]       wr_data = '0;
  logic              tx_out, busy, fifo_empty, fifo_full, overflow, frame_done;
  logic [LVL_W-1:0]  fifo_level;

  int tests = 0;
  int fails = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  typedef struct packed {logic tx; logic bsy; logic done;} samp_t;
  samp_t                wave[$];
  logic [DATA_BITS-1:0] q[$];
  logic                 m_ovf = 1'b0;

  tx_frame_ctrl #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .cfg_enable(cfg_enable), .cfg_parity_en(cfg_parity_en),
    .cfg_baud_div(cfg_baud_div), .ovf_clr(ovf_clr), .wr_valid(wr_valid), .wr_data(wr_data),
    .tx_out(tx_out), .busy(busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_frame(input logic [DATA_BITS-1:0] d, input int div, input bit par);
    bit    bits[$];
    samp_t s;
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) bits.push_back(d[i]);
    if (par) bits.push_back(^d);
    bits.push_back(1'b1);
    foreach (bits[k]) begin
      for (int c = 0; c <= div; c++) begin
        s.tx   = bits[k];
        s.bsy  = 1'b1;
        s.done = (k == bits.size() - 1) && (c == div);
        wave.push_back(s);
      end
    end
  endtask

  task automatic model_edge();
    bit was_idle, do_pop, full;
    if (!ARESETN) begin
      q.delete();
      wave.delete();
      m_ovf = 1'b0;
      return;
    end
    was_idle = (wave.size() == 0);
    full     = (q.size() == FIFO_DEPTH);
    do_pop   = was_idle && cfg_enable && (q.size() > 0);
    if (!was_idle) void'(wave.pop_front());
    if (do_pop) build_frame(q.pop_front(), int'(cfg_baud_div), cfg_parity_en);
    if (wr_valid && (!full || do_pop)) q.push_back(wr_data[DATA_BITS-1:0]);
    if (wr_valid && full && !do_pop) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
  endtask

  task automatic compare_all();
    samp_t e;
    e = (wave.size() > 0) ? wave[0] : samp_t'(3'b100);
    check("tx_out", tx_out, e.tx);
    check("busy", busy, e.bsy);
    check("frame_done", frame_done, e.done);
    check("fifo_level", fifo_level, q.size());
    check("fifo_empty", fifo_empty, q.size() == 0);
    check("fifo_full", fifo_full, q.size() == FIFO_DEPTH);
    check("overflow", overflow, m_ovf);
    if (busy) busy_cnt++;
    if (frame_done) done_cnt++;
  endtask

  task automatic step();
    @(posedge ACLK);
    model_edge();
    @(negedge ACLK);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    run(2);
    ARESETN = 1'b1;
    run(2);

    // Single frame 0xA5, 4-cycle bits
    cfg_enable = 1'b1;
    cfg_baud_div = 16'd3;
    busy_cnt = 0;
    done_cnt = 0;
    write(32'hFFFF_FFA5);
    run(50);
    check("a5_busy_cycles", busy_cnt, 40);
    check("a5_done_pulses", done_cnt, 1);

    // Parity frames at 1 cycle per bit
    cfg_baud_div = 16'd0;
    cfg_parity_en = 1'b1;
    busy_cnt = 0;
    write(32'h07);
    run(15);
    check("par07_busy_cycles", busy_cnt, 11);
    write(32'h03);
    run(15);

    // Fill while disabled, overflow on the fifth write
    cfg_parity_en = 1'b0;
    cfg_enable = 1'b0;
    cfg_baud_div = 16'd1;
    for (int i = 1; i <= 5; i++) write(32'(i * 8'h11));
    check("fill_level", fifo_level, 4);
    check("fill_ovf", overflow, 1);
    cfg_enable = 1'b1;
    done_cnt = 0;
    run(100);
    check("drain_frames", done_cnt, 4);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);

    // Write into a full FIFO on the cycle that pops it
    cfg_enable = 1'b0;
    for (int i = 0; i < 4; i++) write(32'h30 + 32'(i));
    cfg_enable = 1'b1;
    write(32'h5A);
    check("fullpop_level", fifo_level, 4);
    check("fullpop_ovf", overflow, 0);
    run(120);

    // Divisor change mid-frame applies to the next frame only
    cfg_baud_div = 16'd3;
    write(32'h96);
    write(32'h69);
    run(12);
    cfg_baud_div = 16'd7;
    run(150);

    // Enable dropped mid-frame: frame completes, FIFO keeps the rest
    cfg_baud_div = 16'd1;
    write(32'h81);
    write(32'h42);
    run(8);
    cfg_enable = 1'b0;
    run(40);
    check("hold_busy", busy, 0);
    check("hold_level", fifo_level, 1);
    cfg_enable = 1'b1;
    run(30);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      wr_valid = ($urandom_range(0, 3) == 0);
      wr_data  = $urandom;
      ovf_clr  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
      if ($urandom_range(0, 29) == 0) cfg_baud_div = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) cfg_parity_en = ~cfg_parity_en;
      step();
    end
    wr_valid = 1'b0;
    ovf_clr  = 1'b0;

    // Asynchronous reset in the middle of DATA
    cfg_enable = 1'b1;
    cfg_parity_en = 1'b0;
    cfg_baud_div = 16'd3;
    run(80);
    for (int i = 0; i < 7; i++) write(32'hC3 + 32'(i));
    run(6);
    check("pre_reset_busy", busy, 1);
    #2 ARESETN = 1'b0;
    #1;
    check("rst_tx_out", tx_out, 1);
    check("rst_busy", busy, 0);
    check("rst_empty", fifo_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_done", frame_done, 0);
    q.delete();
    wave.delete();
    m_ovf = 1'b0;
    run(2);
    ARESETN = 1'b1;
    busy_cnt = 0;
    run(30);
    check("post_reset_busy_cycles", busy_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
